// File: rtl/psum_collector.sv
// -----------------------------------------------------------------------------
// psum_collector
//
// Downstream stage of a PE in the convolution NoC. Accumulates the 24-bit
// partial-sum payloads of NUM_SRC packets addressed to MY_ADDR and emits one
// result packet {flag, OUT_ADDR, MY_ADDR, acc} toward the output memory node.
//
// Packet layout (WIDTH = 33): [32] flag, [31:28] dest, [27:24] src, [23:0] payload
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input packet valid
//   in_ready   out  collector can accept a packet (low while a result is held)
//   in_data    in   input packet
//   out_valid  out  result packet valid
//   out_ready  in   downstream accepts the result
//   out_data   out  result packet
//   err_pulse  out  one-cycle pulse after a dropped packet or a restart
//   busy       out  high while the state is not IDLE
//
// Configuration macro: PSUM_SAT_EN
//   defined   - accumulation saturates at 24'hFFFFFF and the result flag bit
//               is set for a result that saturated
//   undefined - accumulation wraps modulo 2^24, result flag bit is always 0
// -----------------------------------------------------------------------------
module psum_collector #(
  parameter int         WIDTH    = 33,
  parameter int         NUM_SRC  = 3,
  parameter logic [3:0] MY_ADDR  = 4'b0011,
  parameter logic [3:0] OUT_ADDR = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_pulse,
  output logic             busy
);

  localparam int         PSUM_W    = 24;
  localparam logic [3:0] NUM_SRC_C = 4'(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PSUM_W-1:0]   acc_q, acc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                err_d;
  logic                busy_q;

  // Packet fields
  logic                pkt_flag;
  logic [3:0]          pkt_dest;
  logic [PSUM_W-1:0]   pkt_payload;
  logic                unused_src;

  assign pkt_flag    = in_data[32];
  assign pkt_dest    = in_data[31:28];
  assign pkt_payload = in_data[23:0];
  // The src field plays no part in accumulation.
  assign unused_src  = ^in_data[27:24];

  // Candidate values for an accepted, correctly addressed packet
  logic [PSUM_W:0]     sum;
  logic [PSUM_W-1:0]   acc_next;
  logic [3:0]          cnt_next;
  logic                res_flag;

`ifdef PSUM_SAT_EN
  // Sticky "this result saturated" marker, cleared on restart and in IDLE.
  logic sat_q, sat_d, sat_next;
`endif

  assign in_ready  = (state_q != EMIT);
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  assign sum = {1'b0, acc_q} + {1'b0, pkt_payload};

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    err_d      = 1'b0;
    acc_next   = acc_q;
    cnt_next   = cnt_q;
    res_flag   = 1'b0;
`ifdef PSUM_SAT_EN
    sat_d      = sat_q;
    sat_next   = sat_q;
`endif

    if (pkt_flag) begin
      // Start-of-result: payload seeds a fresh accumulation.
      acc_next = pkt_payload;
      cnt_next = 4'd1;
`ifdef PSUM_SAT_EN
      sat_next = 1'b0;
`endif
    end else begin
      cnt_next = cnt_q + 4'd1;
`ifdef PSUM_SAT_EN
      if (sum[PSUM_W]) begin
        acc_next = {PSUM_W{1'b1}};
        sat_next = 1'b1;
      end else begin
        acc_next = sum[PSUM_W-1:0];
      end
`else
      acc_next = sum[PSUM_W-1:0];
`endif
    end

`ifdef PSUM_SAT_EN
    res_flag = sat_next;
`endif

    case (state_q)
      EMIT: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef PSUM_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      default: begin
        if (in_valid) begin
          if (pkt_dest != MY_ADDR) begin
            // Misrouted packet: swallowed, state untouched.
            err_d = 1'b1;
          end else begin
            // A start flag in the middle of a result discards the partial sum.
            err_d = pkt_flag && (state_q == ACCUM);
            acc_d = acc_next;
            cnt_d = cnt_next;
`ifdef PSUM_SAT_EN
            sat_d = sat_next;
`endif
            if (cnt_next == NUM_SRC_C) begin
              state_d    = EMIT;
              out_data_d = {res_flag, OUT_ADDR, MY_ADDR, acc_next};
            end else begin
              state_d = ACCUM;
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      err_pulse  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PSUM_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      err_pulse  <= err_d;
      // Registered from the next state so busy tracks state_q exactly.
      busy_q     <= (state_d != IDLE);
`ifdef PSUM_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// -----------------------------------------------------------------------------
// tb_psum_collector
//
// Directed stimulus for psum_collector. Expected result packets are pushed
// into a scoreboard queue as stimulus is issued; an independent monitor pops
// and compares on every output handshake and counts err_pulse cycles.
// Inputs change 1 time unit after the rising edge; the monitor samples on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_psum_collector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;
  logic        err_pulse;
  logic        busy;

  psum_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_pulse (err_pulse),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] pkt(input logic f, input logic [3:0] d, input logic [23:0] p);
    return {f, d, 4'b0010, p};
  endfunction

  function automatic logic [32:0] res(input logic f, input logic [23:0] p);
    return {f, 4'b0000, 4'b0011, p};
  endfunction

  // Drive one packet and hold it until the edge that accepts it.
  task automatic send(input logic [32:0] p);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = p;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_pulse) err_cnt++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got %h with no result expected", out_data);
          end else begin
            check("result", out_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  33'(in_ready),  33'd1);
    check("rst_out_valid", 33'(out_valid), 33'd0);
    check("rst_busy",      33'(busy),      33'd0);
    check("rst_out_data",  out_data,       33'd0);
    check("rst_err_pulse", 33'(err_pulse), 33'd0);
    @(posedge clk); #1;

    // Basic: back-to-back, latency of one cycle after the 3rd accept
    exp_q.push_back(res(1'b0, 24'h09085A));
    send(pkt(1'b0, 4'b0011, 24'h000155));
    check("basic_busy_accum", 33'(busy), 33'd1);
    send(pkt(1'b0, 4'b0011, 24'h030201));
    send(pkt(1'b0, 4'b0011, 24'h060504));
    check("basic_latency_out_valid", 33'(out_valid), 33'd1);
    check("basic_in_ready_emit",     33'(in_ready),  33'd0);
    cycles(1);
    check("basic_idle_out_valid", 33'(out_valid), 33'd0);
    check("basic_idle_busy",      33'(busy),      33'd0);

    // Back-pressure: result held stable, extra input not consumed
    out_ready = 1'b0;
    exp_q.push_back(res(1'b0, 24'h09085A));
    send(pkt(1'b0, 4'b0011, 24'h000155));
    send(pkt(1'b0, 4'b0011, 24'h030201));
    send(pkt(1'b0, 4'b0011, 24'h060504));
    in_valid = 1'b1;
    in_data  = pkt(1'b0, 4'b0011, 24'h000777);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check("bp_out_valid", 33'(out_valid), 33'd1);
      check("bp_out_data",  out_data,       res(1'b0, 24'h09085A));
      check("bp_in_ready",  33'(in_ready),  33'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles(1);
    check("bp_after_out_valid", 33'(out_valid), 33'd0);
    check("bp_after_in_ready",  33'(in_ready),  33'd1);
    check("bp_no_err",          33'(err_cnt),   33'd0);

    // Wrong destination between the 1st and 2nd packets
    exp_q.push_back(res(1'b0, 24'h09085A));
    send(pkt(1'b0, 4'b0011, 24'h000155));
    send(pkt(1'b0, 4'b0101, 24'h123456));
    send(pkt(1'b0, 4'b0011, 24'h030201));
    send(pkt(1'b0, 4'b0011, 24'h060504));
    cycles(2);
    check("wrong_dest_err_cnt", 33'(err_cnt), 33'd1);

    // Start flag from IDLE is legal
    exp_q.push_back(res(1'b0, 24'h000012));
    send(pkt(1'b1, 4'b0011, 24'h000005));
    send(pkt(1'b0, 4'b0011, 24'h000006));
    send(pkt(1'b0, 4'b0011, 24'h000007));
    cycles(2);
    check("flag_idle_err_cnt", 33'(err_cnt), 33'd1);

    // Restart mid-ACCUM
    exp_q.push_back(res(1'b0, 24'h000012));
    send(pkt(1'b0, 4'b0011, 24'h000100));
    send(pkt(1'b0, 4'b0011, 24'h000200));
    send(pkt(1'b1, 4'b0011, 24'h000010));
    send(pkt(1'b0, 4'b0011, 24'h000001));
    send(pkt(1'b0, 4'b0011, 24'h000001));
    cycles(2);
    check("restart_err_cnt", 33'(err_cnt), 33'd2);

    // Overflow
`ifdef PSUM_SAT_EN
    exp_q.push_back(res(1'b1, 24'hFFFFFF));
`else
    exp_q.push_back(res(1'b0, 24'h000001));
`endif
    send(pkt(1'b0, 4'b0011, 24'hFFFFFF));
    send(pkt(1'b0, 4'b0011, 24'h000002));
    send(pkt(1'b0, 4'b0011, 24'h000000));
    cycles(2);

    // Following result must carry a clean flag bit
    exp_q.push_back(res(1'b0, 24'h000006));
    send(pkt(1'b0, 4'b0011, 24'h000001));
    send(pkt(1'b0, 4'b0011, 24'h000002));
    send(pkt(1'b0, 4'b0011, 24'h000003));
    cycles(2);

    // Asynchronous reset mid-ACCUM
    send(pkt(1'b0, 4'b0011, 24'h000100));
    send(pkt(1'b0, 4'b0011, 24'h000200));
    #2 rst_n = 1'b0;
    #1;
    check("arst_accum_busy",     33'(busy),     33'd0);
    check("arst_accum_in_ready", 33'(in_ready), 33'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Asynchronous reset mid-EMIT: pending result dropped
    out_ready = 1'b0;
    send(pkt(1'b0, 4'b0011, 24'h000100));
    send(pkt(1'b0, 4'b0011, 24'h000200));
    send(pkt(1'b0, 4'b0011, 24'h000300));
    check("pre_arst_emit_out_valid", 33'(out_valid), 33'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_emit_out_valid", 33'(out_valid), 33'd0);
    check("arst_emit_out_data",  out_data,       33'd0);
    check("arst_emit_busy",      33'(busy),      33'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Accumulator must start clean after reset
    exp_q.push_back(res(1'b0, 24'h09085A));
    send(pkt(1'b0, 4'b0011, 24'h000155));
    send(pkt(1'b0, 4'b0011, 24'h030201));
    send(pkt(1'b0, 4'b0011, 24'h060504));

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cycles(1);
      n++;
    end
    cycles(2);
    check("scoreboard_empty", 33'(exp_q.size()), 33'd0);
    check("final_err_cnt",    33'(err_cnt),      33'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
